// File: rtl/mux_seq_pkg.sv
// Shared constants and state encoding for the operand-mux select sequencer.
package mux_seq_pkg;

  localparam int WIDTH = 5;
  localparam int SEL_W = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/prio_enc4.sv
// Lowest-set-bit priority encoder over a 4-bit vector; bit 0 has highest priority.
module prio_enc4
  import mux_seq_pkg::*;
(
  input  logic [3:0]       vec,
  output logic [SEL_W-1:0] idx,
  output logic             any_set
);

  always_comb begin
    idx = '0;
    if (vec[0])      idx = 2'd0;
    else if (vec[1]) idx = 2'd1;
    else if (vec[2]) idx = 2'd2;
    else if (vec[3]) idx = 2'd3;
  end

  assign any_set = |vec;

endmodule

// File: rtl/mux_sel_sequencer.sv
// Loads four serial entries into the mux data registers, then walks the mux select
// through the masked entries one handshake at a time and pulses done.
//
//   state   | meaning
//   IDLE    | waiting for start; mask is latched on start
//   LOAD    | capturing four din words into data1..data4
//   ISSUE   | out_valid high; sel points at lowest pending entry
//   DONE    | one-cycle done pulse, then back to IDLE
module mux_sel_sequencer
  import mux_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       mask,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data1,
  output logic [WIDTH-1:0] data2,
  output logic [WIDTH-1:0] data3,
  output logic [WIDTH-1:0] data4,
  output logic [SEL_W-1:0] sel,
  output logic             out_valid,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [1:0]       load_cnt;
  logic [3:0]       mask_r;
  logic [3:0]       pending;
  logic [SEL_W-1:0] pend_idx;
  logic             pend_any;
  logic [3:0]       pend_hot;
  logic [3:0]       pend_clr;
  logic             last_issue;

  prio_enc4 u_prio_enc (
    .vec     (pending),
    .idx     (pend_idx),
    .any_set (pend_any)
  );

  assign pend_hot   = 4'b0001 << pend_idx;
  assign pend_clr   = pending & ~pend_hot;
  assign last_issue = ~|pend_clr;

  assign out_valid = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  // pending only changes on a handshake edge, so sel is stable while out_ready is low
  assign sel       = (out_valid && pend_any) ? pend_idx : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      mask_r   <= '0;
      pending  <= '0;
      data1    <= '0;
      data2    <= '0;
      data3    <= '0;
      data4    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mask_r   <= mask;
            load_cnt <= '0;
            state    <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (din_valid) begin
            case (load_cnt)
              2'd0: data1 <= din;
              2'd1: data2 <= din;
              2'd2: data3 <= din;
              2'd3: data4 <= din;
              default: data1 <= din;
            endcase
            load_cnt <= load_cnt + 2'd1;
            if (load_cnt == 2'd3) begin
              if (mask_r != 4'd0) begin
                pending <= mask_r;
                state   <= S_ISSUE;
              end else begin
                state   <= S_DONE;
              end
            end
          end
        end
        S_ISSUE: begin
          if (out_ready) begin
            pending <= pend_clr;
            if (last_issue) state <= S_DONE;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized bench for mux_sel_sequencer against a transaction-level model:
// expected issue order is the ascending list of mask bits, entries are the words sent.
module tb_mux_sel_sequencer;
  import mux_seq_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [3:0]       mask;
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             out_ready;
  logic [WIDTH-1:0] data1, data2, data3, data4;
  logic [SEL_W-1:0] sel;
  logic             out_valid, busy, done;

  int n_cmp = 0;
  int n_err = 0;

  mux_sel_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .mask      (mask),
    .din       (din),
    .din_valid (din_valid),
    .out_ready (out_ready),
    .data1     (data1),
    .data2     (data2),
    .data3     (data3),
    .data4     (data4),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [19:0] data_pack();
    return {data4, data3, data2, data1};
  endfunction

  // One full start/load/issue/done sequence. Checks happen at negedge, drives follow.
  task automatic run_seq(input logic [3:0] m, input logic [19:0] wp, input int p_dv,
                         input int p_rdy, input bit noise, input int stall_sel);
    int q[$];
    int n;
    int guard;
    int stall_left;
    bit dv;
    bit rdy;
    stall_left = 3;
    for (int i = 0; i < 4; i++) if (m[i]) q.push_back(i);

    @(negedge clk);
    chk("idle_busy", busy, 0);
    start = 1'b1;
    mask  = m;
    @(negedge clk);
    start = 1'b0;
    mask  = 4'($urandom);

    n = 0;
    guard = 0;
    while (n < 4) begin
      chk("load_busy", busy, 1);
      chk("load_out_valid", out_valid, 0);
      chk("load_sel", sel, 0);
      chk("load_done", done, 0);
      dv        = ($urandom_range(0, 99) < p_dv);
      din_valid = dv;
      din       = dv ? wp[n*5 +: 5] : 5'($urandom);
      out_ready = 1'($urandom);
      if (noise) begin
        start = 1'($urandom);
        mask  = 4'($urandom);
      end
      if (dv) n++;
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        chk("load_timeout", guard, 0);
        break;
      end
    end

    guard = 0;
    while (q.size() > 0) begin
      chk("issue_out_valid", out_valid, 1);
      chk("issue_sel", sel, q[0]);
      chk("issue_done", done, 0);
      chk("issue_data", data_pack(), wp);
      rdy = ($urandom_range(0, 99) < p_rdy);
      if (q[0] == stall_sel && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      out_ready = rdy;
      din_valid = 1'($urandom);
      din       = 5'($urandom);
      if (noise) begin
        start = 1'($urandom);
        mask  = 4'($urandom);
      end
      if (rdy) void'(q.pop_front());
      @(negedge clk);
      guard++;
      if (guard > 400) begin
        chk("issue_timeout", guard, 0);
        break;
      end
    end

    chk("done_pulse", done, 1);
    chk("done_busy", busy, 1);
    chk("done_out_valid", out_valid, 0);
    chk("done_sel", sel, 0);
    start     = 1'b1;
    din_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_out_valid", out_valid, 0);
    chk("final_data", data_pack(), wp);
  endtask

  task automatic reset_mid_issue();
    logic [19:0] wp;
    wp = 20'($urandom);
    @(negedge clk);
    start = 1'b1;
    mask  = 4'b1111;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din_valid = 1'b1;
      din       = wp[i*5 +: 5];
      @(negedge clk);
    end
    din_valid = 1'b0;
    out_ready = 1'b1;
    chk("rst_seq_sel0", sel, 0);
    @(negedge clk);
    chk("rst_seq_sel1", sel, 1);
    @(negedge clk);
    chk("rst_seq_sel2", sel, 2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_sel", sel, 0);
    chk("async_rst_data", data_pack(), 0);
    start = 1'b1;
    mask  = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_held_busy", busy, 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_busy", busy, 0);
    chk("rst_release_done", done, 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    mask      = '0;
    din       = '0;
    din_valid = 1'b0;
    out_ready = 1'b0;
    #12;
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_sel", sel, 0);
    chk("reset_data", data_pack(), 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(4'b1111, {5'd31, 5'd17, 5'd7, 5'd3}, 100, 100, 1'b0, -1);
    run_seq(4'b1010, 20'($urandom), 50, 100, 1'b0, -1);
    run_seq(4'b1111, 20'($urandom), 100, 100, 1'b0, 2);
    run_seq(4'b0000, 20'($urandom), 100, 100, 1'b0, -1);
    reset_mid_issue();
    run_seq(4'b0110, 20'($urandom), 100, 100, 1'b0, -1);
    for (int k = 0; k < 30; k++)
      run_seq(4'($urandom), 20'($urandom), $urandom_range(30, 100),
              $urandom_range(30, 100), 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
